// File: rtl/pipe_bpred_pkg.sv
// Shared types and constants for the pipe_bpred branch predictor.
package pipe_bpred_pkg;

    localparam int unsigned TAG_MAX_W = 16;

    localparam logic [1:0] CTR_SNT   = 2'd0;
    localparam logic [1:0] CTR_WNT   = 2'd1;
    localparam logic [1:0] CTR_WT    = 2'd2;
    localparam logic [1:0] CTR_ST    = 2'd3;
    localparam logic [1:0] CTR_RESET = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    // Tag is held zero-extended to TAG_MAX_W so the struct has a fixed layout.
    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [1:0]           ctr;
        logic [31:0]          target;
    } entry_t;

    function automatic logic [TAG_MAX_W-1:0] pc_tag(input logic [31:0] pc,
                                                    input int unsigned idx_w,
                                                    input int unsigned tag_w);
        logic [31:0] mask;
        mask = (32'd1 << tag_w) - 32'd1;
        return TAG_MAX_W'((pc >> (idx_w + 2)) & mask);
    endfunction

endpackage

// File: rtl/pipe_bpred_if.sv
// Lookup, update, invalidate and statistics signals of the branch predictor.
interface pipe_bpred_if;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        upd_mispredict;
    logic        inv_all;
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_pred_taken,
               upd_pred_target, inv_all,
        input  pred_taken, pred_target, upd_mispredict, stat_updates, stat_mispredicts
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_pred_taken,
               upd_pred_target, inv_all,
        output pred_taken, pred_target, upd_mispredict, stat_updates, stat_mispredicts
    );
endinterface

// File: rtl/pipe_bpred_ctr.sv
// Two-bit saturating direction counter, next-state only.
module pipe_bpred_ctr
    import pipe_bpred_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_nxt
);

    always_comb begin
        ctr_nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) ctr_nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_nxt = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/pipe_bpred.sv
// Direct-mapped tagged branch predictor with 2-bit counters and targets.
// Define BPRED_STATS_EN to build the update/mispredict event counters.
module pipe_bpred
    import pipe_bpred_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 8
) (
    input logic          clk,
    input logic          reset,
    pipe_bpred_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    entry_t                tbl_q [ENTRIES];
    logic [IDX_W-1:0]      lk_idx;
    logic [TAG_MAX_W-1:0]  lk_tag;
    entry_t                lk_ent;
    logic                  lk_hit;
    logic [IDX_W-1:0]      upd_idx;
    logic [TAG_MAX_W-1:0]  upd_tag;
    entry_t                cur;
    logic                  upd_hit;
    logic                  accept;
    logic [1:0]            ctr_nxt;
    logic                  wr_en;
    entry_t                wr_entry;

    // Lookup: reads state only, so an update in the same cycle is not visible.
    assign lk_idx = bus.if_pc[IDX_W+1:2];
    assign lk_tag = pc_tag(bus.if_pc, IDX_W, TAG_W);
    assign lk_ent = tbl_q[lk_idx];
    assign lk_hit = lk_ent.valid && (lk_ent.tag == lk_tag);

    assign bus.pred_taken  = lk_hit && lk_ent.ctr[1] && !bus.if_pc[31];
    assign bus.pred_target = bus.pred_taken ? lk_ent.target : 32'd0;

    assign bus.upd_mispredict = bus.upd_valid &&
        ((bus.upd_taken != bus.upd_pred_taken) ||
         (bus.upd_taken && (bus.upd_pred_target != bus.upd_target)));

    assign upd_idx = bus.upd_pc[IDX_W+1:2];
    assign upd_tag = pc_tag(bus.upd_pc, IDX_W, TAG_W);
    assign cur     = tbl_q[upd_idx];
    assign upd_hit = cur.valid && (cur.tag == upd_tag);
    assign accept  = bus.upd_valid && !bus.upd_pc[31] && !bus.inv_all;

    pipe_bpred_ctr u_ctr (
        .ctr     (cur.ctr),
        .taken   (bus.upd_taken),
        .ctr_nxt (ctr_nxt)
    );

    always_comb begin
        wr_en    = 1'b0;
        wr_entry = cur;
        if (accept) begin
            if (upd_hit) begin
                wr_en        = 1'b1;
                wr_entry.ctr = ctr_nxt;
                if (bus.upd_taken) wr_entry.target = bus.upd_target;
            end else if (bus.upd_taken) begin
                wr_en    = 1'b1;
                wr_entry = '{valid: 1'b1, tag: upd_tag, ctr: CTR_ALLOC,
                             target: bus.upd_target};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tbl_q[i] <= '{valid: 1'b0, tag: '0, ctr: CTR_RESET, target: 32'd0};
            end
        end else if (bus.inv_all) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tbl_q[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            tbl_q[upd_idx] <= wr_entry;
        end
    end

`ifdef BPRED_STATS_EN
    logic [31:0] stat_upd_q;
    logic [31:0] stat_mis_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_upd_q <= 32'd0;
            stat_mis_q <= 32'd0;
        end else begin
            if (accept && (stat_upd_q != 32'hFFFF_FFFF)) stat_upd_q <= stat_upd_q + 32'd1;
            if (bus.upd_mispredict && (stat_mis_q != 32'hFFFF_FFFF)) begin
                stat_mis_q <= stat_mis_q + 32'd1;
            end
        end
    end

    assign bus.stat_updates     = stat_upd_q;
    assign bus.stat_mispredicts = stat_mis_q;
`else
    assign bus.stat_updates     = 32'd0;
    assign bus.stat_mispredicts = 32'd0;
`endif

endmodule
